// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// Expands one padded 512-bit message block into the SHA-256 message schedule
// W[0:ROUNDS-1]. The block is loaded on a start edge and one new word is
// written per clock. done stays high, and W is held, until the next start.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     request expansion of block_in (sampled on posedge)
//   block_in  512-bit block, [511:480] = M0 ... [31:0] = M15
//   busy      high from the load edge through the final word write
//   done      level, high while W[0:ROUNDS-1] is complete and stable
//   W         schedule array, W[0] in the most significant word
module sha256_msg_sched #(
  parameter int ROUNDS      = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [511:0]        block_in,
  output logic                busy,
  output logic                done,
  output logic [0:63][31:0]   W
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [5:0] T_FIRST = 6'(BLOCK_WORDS);
  localparam logic [5:0] T_LAST  = 6'(ROUNDS - 1);

  state_t             state_q, state_d;
  logic [5:0]         t_q;
  logic [0:63][31:0]  w_q;
  logic [0:63][31:0]  load_w;
  logic [31:0]        w_new;
  logic               load, step, last;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Words beyond the loaded block start at zero so unwritten entries read 0.
  assign load_w = {block_in, {((64 - BLOCK_WORDS) * 32){1'b0}}};

  // Sum wraps naturally at 32 bits; the carry out of bit 31 is dropped.
  assign w_new = sig1(w_q[t_q - 6'd2]) + w_q[t_q - 6'd7]
               + sig0(w_q[t_q - 6'd15]) + w_q[t_q - 6'd16];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        // start is deliberately ignored here: no queuing of a second block.
        step = 1'b1;
        if (t_q == T_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stage: schedule storage and write index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q <= '0;
      t_q <= '0;
    end else if (load) begin
      w_q <= load_w;
      t_q <= T_FIRST;
    end else if (step) begin
      w_q[t_q] <= w_new;
      // Hold t on the final write so it never wraps past 63.
      if (!last) t_q <= t_q + 6'd1;
    end
  end

  assign busy = (state_q == EXPAND);
  assign done = (state_q == DONE);
  assign W    = w_q;

endmodule
